bus_arbiter_rr: RTL and testbench

Round-robin arbiter for the shared system bus, granting ownership to one of several bus masters (camera grabber, DMA, CPU-side masters) at a time. It samples each master's `requestBus`, drives the one-hot `busGrant` lines, and tracks bus ownership by watching the shared begin/end/error transaction signals. It prevents a stalled master from locking the bus, with an optional grant-timeout watchdog.

---
 rtl/bus_arbiter_rr.sv | 150 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: one-hot grant, ownership tracked via shared begin/end/error strobes.
// Latency: request -> grant 2 edges (request register + arbitration), end/error -> grant low 1 edge.
// Backpressure: none; requests are level-held, grant is held until end/error (or watchdog with BUS_ARBITER_TIMEOUT_EN).
module bus_arbiter_rr #(
    parameter int NR_OF_MASTERS  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NR_OF_MASTERS-1:0] requestIn,
    input  logic                     beginTransactionIn,
    input  logic                     endTransactionIn,
    input  logic                     busErrorIn,
    output logic [NR_OF_MASTERS-1:0] grantOut,
    output logic [2:0]               grantIdOut,
    output logic                     busOwnedOut,
    output logic                     timeoutOut
);

    if (NR_OF_MASTERS < 2 || NR_OF_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : gBadParams
        $error("bus_arbiter_rr: illegal parameter values");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } stateT;

    stateT                     state;
    stateT                     stateNext;
    logic [NR_OF_MASTERS-1:0]  requestReg;
    logic [NR_OF_MASTERS-1:0]  grantNext;
    logic [2:0]                lastId;
    logic [2:0]                lastIdNext;
    logic [2:0]                grantIdNext;
    logic [2:0]                winnerId;
    logic                      winnerFound;
    logic                      ownedNext;
    logic                      watchdogExpire;
    int                        bestDist;

    // Distance of a master from the rotating search start (lastId+1).
    function automatic int searchDist(input int idx, input logic [2:0] last);
        return (idx + NR_OF_MASTERS - 1 - int'(last)) % NR_OF_MASTERS;
    endfunction

    always_comb begin
        winnerFound = 1'b0;
        winnerId    = '0;
        bestDist    = NR_OF_MASTERS;
        for (int j = 0; j < NR_OF_MASTERS; j++) begin
            if (requestReg[j] && searchDist(j, lastId) < bestDist) begin
                bestDist    = searchDist(j, lastId);
                winnerId    = 3'(j);
                winnerFound = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        grantNext   = grantOut;
        grantIdNext = grantIdOut;
        lastIdNext  = lastId;
        case (state)
            IDLE: begin
                if (!busErrorIn && winnerFound) begin
                    stateNext   = GRANT;
                    grantNext   = NR_OF_MASTERS'(1) << winnerId;
                    grantIdNext = winnerId;
                    lastIdNext  = winnerId;
                end
            end
            GRANT: begin
                if (busErrorIn) begin
                    stateNext = RELEASE;
                end else if (beginTransactionIn) begin
                    // A zero-length transaction (begin and end together) frees the bus at once.
                    stateNext = endTransactionIn ? RELEASE : ACTIVE;
                end else if (watchdogExpire) begin
                    stateNext = RELEASE;
                end
            end
            ACTIVE: begin
                if (busErrorIn || endTransactionIn) begin
                    stateNext = RELEASE;
                end
            end
            RELEASE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (stateNext == RELEASE || stateNext == IDLE) begin
            grantNext = '0;
        end
    end

    assign ownedNext = (stateNext == GRANT) || (stateNext == ACTIVE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            requestReg  <= '0;
            lastId      <= 3'(NR_OF_MASTERS - 1);
            grantOut    <= '0;
            grantIdOut  <= '0;
            busOwnedOut <= 1'b0;
        end else begin
            state       <= stateNext;
            requestReg  <= requestIn;
            lastId      <= lastIdNext;
            grantOut    <= grantNext;
            grantIdOut  <= grantIdNext;
            busOwnedOut <= ownedNext;
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CntW-1:0] watchdogCount;
    logic            timeoutFlag;

    // Expire on the edge where the count would reach TIMEOUT_CYCLES, i.e. after exactly that many GRANT cycles.
    assign watchdogExpire = (state == GRANT) && (watchdogCount == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            watchdogCount <= '0;
            timeoutFlag   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                watchdogCount <= '0;
            end else if (state == GRANT) begin
                watchdogCount <= watchdogCount + CntW'(1);
            end
            if (watchdogExpire && !busErrorIn && !beginTransactionIn) begin
                timeoutFlag <= 1'b1;
            end
        end
    end

    assign timeoutOut = timeoutFlag;
`else
    assign watchdogExpire = 1'b0;
    assign timeoutOut     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomized scoreboard bench for bus_arbiter_rr; the monitor pops expected winners on each new grant.
module tb_bus_arbiter_rr;
    localparam int N  = 4;
    localparam int TO = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] requestIn;
    logic         beginTransactionIn;
    logic         endTransactionIn;
    logic         busErrorIn;
    logic [N-1:0] grantOut;
    logic [2:0]   grantIdOut;
    logic         busOwnedOut;
    logic         timeoutOut;

    int           errors = 0;
    int           checks = 0;
    int           expQ[$];
    int           modelLast = N - 1;
    logic [N-1:0] prevGrant = '0;
    int           monExp;

    bus_arbiter_rr #(.NR_OF_MASTERS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock),
        .reset(reset),
        .requestIn(requestIn),
        .beginTransactionIn(beginTransactionIn),
        .endTransactionIn(endTransactionIn),
        .busErrorIn(busErrorIn),
        .grantOut(grantOut),
        .grantIdOut(grantIdOut),
        .busOwnedOut(busOwnedOut),
        .timeoutOut(timeoutOut)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: first requester found walking upward from the last winner, with wrap.
    function automatic int modelPick(input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(modelLast + k) % N]) return (modelLast + k) % N;
        end
        return -1;
    endfunction

    task automatic expectWinner(input logic [N-1:0] req, output int w);
        w = modelPick(req);
        expQ.push_back(w);
        modelLast = w;
    endtask

    // Scoreboard monitor: compares every newly appearing grant with the next expected winner.
    always @(negedge clock) begin
        if (reset === 1'b1 && grantOut != '0 && prevGrant == '0) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got %0h expected no grant", grantOut);
            end else begin
                monExp = expQ.pop_front();
                check("grant_onehot", 32'(grantOut), 32'(1) << monExp);
                check("grant_id", 32'(grantIdOut), 32'(monExp));
                check("bus_owned_on_grant", 32'(busOwnedOut), 32'd1);
            end
        end
        prevGrant = grantOut;
    end

    task automatic waitGrant(output int cyc);
        cyc = 0;
        while (grantOut == '0 && cyc < 12) begin
            @(negedge clock);
            cyc++;
        end
        if (grantOut == '0) begin
            checks++;
            errors++;
            $display("FAIL grant_wait: got no grant expected one within 12 cycles");
        end
    endtask

    task automatic holdCycles(input int n, input logic [N-1:0] g, inout bit held);
        repeat (n) begin
            @(negedge clock);
            if (grantOut !== g) held = 1'b0;
        end
    endtask

    task automatic pulseBegin(input logic [N-1:0] g, inout bit held);
        beginTransactionIn = 1'b1;
        @(negedge clock);
        beginTransactionIn = 1'b0;
        if (grantOut !== g) held = 1'b0;
    endtask

    // Drives the closing strobe(s) and checks the grant falls one edge later.
    task automatic closeTxn(input logic b, input logic e, input logic err, input bit held, input string tag);
        beginTransactionIn = b;
        endTransactionIn   = e;
        busErrorIn         = err;
        @(negedge clock);
        beginTransactionIn = 1'b0;
        endTransactionIn   = 1'b0;
        busErrorIn         = 1'b0;
        check({tag, "_grant_held"}, 32'(held), 32'd1);
        check({tag, "_release_low"}, 32'(grantOut), 32'd0);
        check({tag, "_release_owned"}, 32'(busOwnedOut), 32'd0);
    endtask

    task automatic randTxn();
        logic [N-1:0] req;
        logic [N-1:0] g;
        int w, cyc, mode, d;
        bit held;
        req = N'($urandom_range(1, (1 << N) - 1));
        expectWinner(req, w);
        g = N'(1) << w;
        requestIn = req;
        waitGrant(cyc);
        check("rand_latency", 32'(cyc), 32'd2);
        requestIn = '0;
        held = 1'b1;
        mode = $urandom_range(0, 3);
        d = $urandom_range(0, 3);
        case (mode)
            0: begin
                holdCycles(d, g, held);
                pulseBegin(g, held);
                holdCycles($urandom_range(1, 16), g, held);
                closeTxn(1'b0, 1'b1, 1'b0, held, "rand_end");
            end
            1: begin
                holdCycles(d, g, held);
                closeTxn(1'b0, 1'b0, 1'b1, held, "rand_err_grant");
            end
            2: begin
                pulseBegin(g, held);
                holdCycles(d, g, held);
                closeTxn(1'b0, $urandom_range(0, 1) == 1, 1'b1, held, "rand_err_active");
            end
            default: begin
                holdCycles(d, g, held);
                closeTxn(1'b1, 1'b1, 1'b0, held, "rand_begin_end");
            end
        endcase
        @(negedge clock);
        check("rand_id_hold_idle", 32'(grantIdOut), 32'(w));
    endtask

    initial begin : watchdogTimer
        #500000;
        $display("FAIL sim_timeout: got no completion expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int w, cyc;
        bit held;
        logic [N-1:0] g;
        reset = 1'b0;
        requestIn = '0;
        beginTransactionIn = 1'b0;
        endTransactionIn = 1'b0;
        busErrorIn = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        check("reset_grant", 32'(grantOut), 32'd0);
        check("reset_owned", 32'(busOwnedOut), 32'd0);
        check("reset_id", 32'(grantIdOut), 32'd0);
        check("reset_timeout", 32'(timeoutOut), 32'd0);

        // Rotation with all masters requesting continuously.
        requestIn = '1;
        for (int k = 0; k < 5; k++) begin
            expectWinner('1, w);
            g = N'(1) << w;
            waitGrant(cyc);
            check(k == 0 ? "rot_latency" : "rot_gap_low_cycles", 32'(cyc), 32'd2);
            held = 1'b1;
            pulseBegin(g, held);
            holdCycles(3, g, held);
            if (k == 4) requestIn = '0;
            closeTxn(1'b0, 1'b1, 1'b0, held, "rot");
        end
        repeat (2) @(negedge clock);

        // Camera-style: master 2 only, request dropped after the grant, 16 beats.
        requestIn = 4'b0100;
        expectWinner(4'b0100, w);
        waitGrant(cyc);
        check("cam_latency", 32'(cyc), 32'd2);
        check("cam_id", 32'(grantIdOut), 32'd2);
        requestIn = '0;
        held = 1'b1;
        holdCycles(2, 4'b0100, held);
        pulseBegin(4'b0100, held);
        holdCycles(16, 4'b0100, held);
        closeTxn(1'b0, 1'b1, 1'b0, held, "cam");
        @(negedge clock);

        // Bus errors in ACTIVE and then in GRANT with everyone still requesting.
        requestIn = '1;
        for (int k = 0; k < 3; k++) begin
            expectWinner('1, w);
            g = N'(1) << w;
            waitGrant(cyc);
            held = 1'b1;
            if (k != 1) pulseBegin(g, held);
            if (k == 2) requestIn = '0;
            closeTxn(1'b0, 1'b0, 1'b1, held, k == 1 ? "err_in_grant" : "err_in_active");
        end
        repeat (2) @(negedge clock);

`ifdef BUS_ARBITER_TIMEOUT_EN
        requestIn = 4'b0010;
        expectWinner(4'b0010, w);
        waitGrant(cyc);
        requestIn = 4'b0100;
        expectWinner(4'b0100, w);
        cyc = 1;
        while (grantOut != '0 && cyc < 40) begin
            @(negedge clock);
            if (grantOut != '0) cyc++;
        end
        check("wd_grant_cycles", 32'(cyc), 32'(TO));
        check("wd_timeout_set", 32'(timeoutOut), 32'd1);
        waitGrant(cyc);
        requestIn = '0;
        closeTxn(1'b0, 1'b0, 1'b1, 1'b1, "wd_next");
        check("wd_timeout_sticky", 32'(timeoutOut), 32'd1);
        @(negedge clock);
`else
        requestIn = 4'b0010;
        expectWinner(4'b0010, w);
        waitGrant(cyc);
        requestIn = '0;
        held = 1'b1;
        holdCycles(100, 4'b0010, held);
        check("nowd_timeout_low", 32'(timeoutOut), 32'd0);
        closeTxn(1'b0, 1'b0, 1'b1, held, "nowd_hold");
        @(negedge clock);
`endif

        for (int k = 0; k < 30; k++) randTxn();

        // Asynchronous reset in the middle of a burst.
        requestIn = 4'b1000;
        expectWinner(4'b1000, w);
        waitGrant(cyc);
        requestIn = '0;
        held = 1'b1;
        pulseBegin(4'b1000, held);
        holdCycles(3, 4'b1000, held);
        #2;
        reset = 1'b0;
        #1;
        check("arst_grant_now", 32'(grantOut), 32'd0);
        check("arst_owned_now", 32'(busOwnedOut), 32'd0);
        check("arst_id_now", 32'(grantIdOut), 32'd0);
        modelLast = N - 1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        requestIn = '1;
        expectWinner('1, w);
        waitGrant(cyc);
        check("arst_first_winner", 32'(grantIdOut), 32'd0);
        requestIn = '0;
        closeTxn(1'b1, 1'b1, 1'b0, 1'b1, "arst_after");
        repeat (2) @(negedge clock);

        check("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
